// File: rtl/fp_pkg.sv
// Shared definitions for the FP compare operand-preparation block:
// class bit positions, format codes, canonical NaNs and entry layout.
package fp_pkg;

   // Sign bit plus 64-bit magnitude handed to the comparator.
   localparam int OP_W  = 65;
   localparam int CLS_W = 10;

   // One-hot class bit positions (RISC-V fclass ordering).
   localparam int CLS_NINF  = 0;
   localparam int CLS_NNORM = 1;
   localparam int CLS_NSUB  = 2;
   localparam int CLS_NZERO = 3;
   localparam int CLS_PZERO = 4;
   localparam int CLS_PSUB  = 5;
   localparam int CLS_PNORM = 6;
   localparam int CLS_PINF  = 7;
   localparam int CLS_SNAN  = 8;
   localparam int CLS_QNAN  = 9;

   localparam logic FMT_S = 1'b0;
   localparam logic FMT_D = 1'b1;

   // Canonical quiet NaNs; a single that is not NaN-boxed becomes QNAN_S.
   localparam logic [31:0] QNAN_S = 32'h7FC0_0000;
   localparam logic [63:0] QNAN_D = 64'h7FF8_0000_0000_0000;

   typedef logic [OP_W-1:0]  ext_t;
   typedef logic [CLS_W-1:0] cls_t;

   // One buffered operand pair as presented to the comparator.
   typedef struct packed {
      ext_t       data1;
      ext_t       data2;
      cls_t       class1;
      cls_t       class2;
      logic [2:0] rm;
   } entry_t;

   function automatic cls_t cls_onehot(input int idx);
      return cls_t'(1) << idx;
   endfunction

endpackage

// File: rtl/fp_cmp_prep_if.sv
// Operand-pair handshake bus: upstream valid/ready channel carrying raw
// operands in, downstream valid/ready channel carrying prepared operands out.
interface fp_cmp_prep_if;
   import fp_pkg::*;

   logic       in_valid;
   logic       in_ready;
   logic       in_fmt;
   logic [63:0] in_op1;
   logic [63:0] in_op2;
   logic [2:0] in_rm;

   logic       out_valid;
   logic       out_ready;
   ext_t       out_data1;
   ext_t       out_data2;
   cls_t       out_class1;
   cls_t       out_class2;
   logic [2:0] out_rm;

   // Environment side: produces operands and consumes prepared pairs.
   modport master (
      output in_valid, in_fmt, in_op1, in_op2, in_rm, out_ready,
      input  in_ready, out_valid, out_data1, out_data2,
             out_class1, out_class2, out_rm
   );

   // Block side.
   modport slave (
      input  in_valid, in_fmt, in_op1, in_op2, in_rm, out_ready,
      output in_ready, out_valid, out_data1, out_data2,
             out_class1, out_class2, out_rm
   );

endinterface

// File: rtl/fp_classify.sv
// Combinational operand unpack: sign-extends a single or double operand to
// {sign, 64-bit magnitude} and produces its one-hot RISC-V class.
module fp_classify
   import fp_pkg::*;
(
   input  logic        fmt,
   input  logic [63:0] op,
   output ext_t        ext,
   output cls_t        cls
);

   logic [31:0] sval;
   logic        sign;
   logic        exp_zero;
   logic        exp_ones;
   logic        frac_zero;
   logic        frac_msb;

   // Field extraction; an improperly boxed single is replaced by the
   // canonical qNaN before anything else looks at it.
   always_comb begin
      sval      = (&op[63:32]) ? op[31:0] : QNAN_S;
      sign      = 1'b0;
      ext       = '0;
      exp_zero  = 1'b0;
      exp_ones  = 1'b0;
      frac_zero = 1'b0;
      frac_msb  = 1'b0;
      if (fmt == FMT_D) begin
         sign      = op[63];
         ext       = {op[63], 1'b0, op[62:0]};
         exp_zero  = (op[62:52] == 11'd0);
         exp_ones  = &op[62:52];
         frac_zero = (op[51:0] == 52'd0);
         frac_msb  = op[51];
      end else begin
         sign      = sval[31];
         ext       = {sval[31], 33'd0, sval[30:0]};
         exp_zero  = (sval[30:23] == 8'd0);
         exp_ones  = &sval[30:23];
         frac_zero = (sval[22:0] == 23'd0);
         frac_msb  = sval[22];
      end
   end

   // Class decode; every path sets exactly one bit.
   always_comb begin
      cls = '0;
      if (exp_ones) begin
         if (frac_zero)
            cls = cls_onehot(sign ? CLS_NINF : CLS_PINF);
         else if (frac_msb)
            cls = cls_onehot(CLS_QNAN);
         else
            cls = cls_onehot(CLS_SNAN);
      end else if (exp_zero) begin
         if (frac_zero)
            cls = cls_onehot(sign ? CLS_NZERO : CLS_PZERO);
         else
            cls = cls_onehot(sign ? CLS_NSUB : CLS_PSUB);
      end else begin
         cls = cls_onehot(sign ? CLS_NNORM : CLS_PNORM);
      end
   end

endmodule

// File: rtl/fp_cmp_prep.sv
// FP compare operand preparation: classifies both operands of an accepted
// pair and queues the result in a small FIFO in front of the comparator.
// Everything at the output comes from registered state, so there is no
// combinational path from the input channel to the output channel.
module fp_cmp_prep
   import fp_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   fp_cmp_prep_if.slave       bus
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [2:0]       CNT_FULL = 3'(DEPTH);

   logic [63:0] op_arr  [2];
   ext_t        ext_arr [2];
   cls_t        cls_arr [2];

   assign op_arr[0] = bus.in_op1;
   assign op_arr[1] = bus.in_op2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cls
         fp_classify u_classify (
            .fmt (bus.in_fmt),
            .op  (op_arr[gi]),
            .ext (ext_arr[gi]),
            .cls (cls_arr[gi])
         );
      end
   endgenerate

   logic [2:0]       count_reg,  count_next;
   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic             accept;
   logic             pop;
   entry_t           wr_entry;
   entry_t           head;
   entry_t           mem [DEPTH];

   assign bus.in_ready  = (count_reg < CNT_FULL);
   assign bus.out_valid = (count_reg != 3'd0);
   assign accept        = bus.in_valid & bus.in_ready;
   assign pop           = bus.out_valid & bus.out_ready;

   assign wr_entry = '{data1:  ext_arr[0],
                       data2:  ext_arr[1],
                       class1: cls_arr[0],
                       class2: cls_arr[1],
                       rm:     bus.in_rm};

   // Next count/pointers; flush discards everything and wins over accept/pop.
   always_comb begin
      count_next  = count_reg;
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      if (flush) begin
         count_next  = 3'd0;
         wr_ptr_next = '0;
         rd_ptr_next = '0;
      end else begin
         if (accept)
            wr_ptr_next = (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_next = (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
         if (accept && !pop)
            count_next = count_reg + 3'd1;
         else if (pop && !accept)
            count_next = count_reg - 3'd1;
      end
   end

   // Occupancy and pointer registers; reset overrides everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg  <= 3'd0;
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         count_reg  <= count_next;
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
      end
   end

   // Entry storage; contents are only meaningful while counted as valid.
   always_ff @(posedge clk) begin
      if (accept)
         mem[wr_ptr_reg] <= wr_entry;
   end

   assign head           = mem[rd_ptr_reg];
   assign bus.out_data1  = head.data1;
   assign bus.out_data2  = head.data2;
   assign bus.out_class1 = head.class1;
   assign bus.out_class2 = head.class2;
   assign bus.out_rm     = head.rm;

endmodule

// File: doc/fp_cmp_prep.md
FP_CMP_PREP -- requirements
Module: fp_cmp_prep

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning output buffer entries (legal range 1..4).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-005 SHALL have port in_valid  input  1  upstream operand pair valid.
REQ-006 SHALL have port in_ready  output  1  block accepts an entry this cycle.
REQ-007 SHALL have port in_fmt  input  1  0 = single (NaN-boxed in 64 bits), 1 = double.
REQ-008 SHALL have ports in_op1, in_op2  input  64  raw register operands.
REQ-009 SHALL have port in_rm  input  3  compare select: 0 FLE, 1 FLT, 2 FEQ; passed through.
REQ-010 SHALL have port out_valid  output  1  head entry valid.
REQ-011 SHALL have port out_ready  input  1  comparator consumes head entry.
REQ-012 SHALL have ports out_data1, out_data2  output  65  {sign, 64-bit magnitude} for the comparator.
REQ-013 SHALL have ports out_class1, out_class2  output  10  one-hot RISC-V class of each operand.
REQ-014 SHALL have port out_rm  output  3  in_rm of head entry.

Function
REQ-015 SHALL classify one-hot: bit0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
REQ-016 Double: sign = op[63]; magnitude = {1'b0, op[62:0]}; exp = op[62:52]; frac = op[51:0].
REQ-017 Single: sign = op[31]; magnitude = {33'b0, op[30:0]}; exp = op[30:23]; frac = op[22:0].
REQ-018 Single with op[63:32] != 32'hFFFFFFFF SHALL be replaced by canonical qNaN 32'h7FC00000 before classification and extension (class bit 9, sign 0).
REQ-019 NaN split: exp all-ones, frac != 0; frac MSB 1 -> qNaN, else sNaN.
REQ-020 Exactly one out_class bit SHALL be set whenever out_valid = 1.
REQ-021 Accept occurs when in_valid & in_ready; pop occurs when out_valid & out_ready.
REQ-022 Buffer SHALL be a DEPTH-entry FIFO with count register; in_ready = (count < DEPTH); out_valid = (count != 0).
REQ-023 Latency SHALL be exactly one cycle: entry accepted in cycle N is presented at head no earlier than cycle N+1; no combinational in->out path.
REQ-024 Simultaneous accept and pop at count = DEPTH SHALL NOT be allowed (in_ready = 0); at 0 < count < DEPTH count is unchanged.
REQ-025 Read/write pointers SHALL wrap modulo DEPTH.
REQ-026 Outputs SHALL hold stable while out_valid & !out_ready.
REQ-027 flush SHALL set count and pointers to 0 next cycle, overriding same-cycle accept and pop.
REQ-028 in_rm values 3..7 SHALL be passed through unmodified; classification unaffected.

Reset
REQ-029 rst SHALL zero count and pointers next edge; out_valid = 0, in_ready = 1 in the following cycle.
REQ-030 rst SHALL take priority over flush, accept and pop; entries in flight are discarded.
REQ-031 Data/class storage need not be reset; out_data*, out_class*, out_rm are don't-care while out_valid = 0.

Structure
REQ-032 Shared package fp_pkg SHALL hold class bit index constants (CLS_NINF..CLS_QNAN), FMT_S/FMT_D, canonical qNaN constants, and the 65-bit operand width.
REQ-033 Combinational sub-module fp_classify (fmt, op -> ext65, class10) SHALL be instantiated twice; FIFO logic lives in fp_cmp_prep.

Verification
REQ-034 fmt = 1, op1 = 64'h3FF0000000000000, op2 = 64'hBFF0000000000000 -> next cycle out_data1 = {0, 64'h3FF0000000000000}, class1 = bit6; out_data2 = {1, 64'h3FF0000000000000}, class2 = bit1.
REQ-035 fmt = 0, op1 = 64'hFFFFFFFF7F800001, op2 = 64'h00000000_3F800000 -> class1 = bit8 (sNaN); op2 not boxed -> class2 = bit9, out_data2 = {0, 64'h7FC00000}.
REQ-036 fmt = 1, op1 = 64'h8000000000000000, op2 = 64'h0000000000000001 -> class1 = bit3, class2 = bit5.
REQ-037 DEPTH = 2, out_ready = 0, three back-to-back valids -> two accepted, in_ready = 0 on third; release out_ready -> entries emerge in order, none lost or duplicated.
REQ-038 count = 1 with flush and accept same cycle -> next cycle out_valid = 0, count = 0; rst asserted with count = 2 -> out_valid = 0, in_ready = 1 following cycle.
